// File: rtl/stack_unit_pkg.sv
// -----------------------------------------------------------------------------
// stack_unit_pkg
// Shared constants and types for the operand stack.
//   DATA_W        : data word width, shared with the register stage and ALU
//   STACK_ADDR_W  : default stack pointer width (DEPTH = 2**STACK_ADDR_W)
//   FLAG_*        : bit positions when the control unit packs the stack flags
//                   into a status word
//   stack_op_e    : decoded stack operation for one cycle
// -----------------------------------------------------------------------------
package stack_unit_pkg;

    localparam int DATA_W       = 16;
    localparam int STACK_ADDR_W = 4;

    localparam int FLAG_EMPTY     = 0;
    localparam int FLAG_FULL      = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 3;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

endpackage : stack_unit_pkg

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// DEPTH x WIDTH storage for the deeper stack entries.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : asynchronous read index
//   rdata  : entry at raddr
// -----------------------------------------------------------------------------
module stack_mem
    import stack_unit_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = STACK_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the owner only ever selects entries it has
    // written, so clearing the array would cost logic and buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : stack_mem

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// LIFO operand stack with fully registered TOS/NOS outputs.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   push      : push w_data
//   pop       : pop top entry (push+pop with a non-empty stack replaces top)
//   w_data    : word to push
//   err_clr   : clear sticky overflow/underflow
//   tos, nos  : top / next entry (0 when not present)
//   count     : number of valid entries, 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky, push while full
//   underflow : sticky, pop while empty
// -----------------------------------------------------------------------------
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = STACK_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  tos,
    output logic [WIDTH-1:0]  nos,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_W);

    stack_op_e         op;
    logic [CNT_W-1:0]  count_next;
    logic [WIDTH-1:0]  tos_next;
    logic [WIDTH-1:0]  nos_next;
    logic              overflow_next;
    logic              underflow_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WIDTH-1:0]  mem_rdata;

    // Entry that becomes NOS after a pop; forced to 0 when fewer than three
    // entries exist so the read never lands on an unwritten slot.
    assign mem_raddr = (count >= CNT_W'(3)) ? ADDR_W'(count - CNT_W'(3)) : '0;

    stack_mem #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & rst_n),
        .waddr (mem_waddr),
        .wdata (w_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Push+pop on an empty stack has nothing to replace, so it is a plain push.
    always_comb begin
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        count_next     = count;
        tos_next       = tos;
        nos_next       = nos;
        overflow_next  = overflow & ~err_clr;
        underflow_next = underflow & ~err_clr;
        mem_we         = 1'b0;
        mem_waddr      = count[ADDR_W-1:0];

        unique case (op)
            OP_PUSH: begin
                if (full) begin
                    overflow_next = 1'b1;
                end else begin
                    mem_we     = 1'b1;
                    count_next = count + CNT_W'(1);
                    tos_next   = w_data;
                    nos_next   = tos;
                end
            end
            OP_POP: begin
                if (empty) begin
                    underflow_next = 1'b1;
                end else begin
                    count_next = count - CNT_W'(1);
                    tos_next   = nos;
                    nos_next   = (count >= CNT_W'(3)) ? mem_rdata : '0;
                end
            end
            OP_REPLACE: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(count - CNT_W'(1));
                tos_next  = w_data;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            tos       <= '0;
            nos       <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            tos       <= tos_next;
            nos       <= nos_next;
            empty     <= (count_next == '0);
            full      <= (count_next == DEPTH_C);
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Directed bench for stack_unit with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic [15:0] w_data;
    logic        err_clr;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int tests_run;
    int tests_failed;

    stack_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .w_data    (w_data),
        .err_clr   (err_clr),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given controls; returns 1 unit after the edge.
    task automatic step(input logic p, input logic q, input logic [15:0] d, input logic c);
        @(negedge clk);
        push    = p;
        pop     = q;
        w_data  = d;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        w_data  = '0;
        err_clr = 1'b0;

        // Reset state
        idle();
        idle();
        rst_n = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_tos", 32'(tos), 0);
        check("rst_nos", 32'(nos), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);

        // Three pushes
        step(1'b1, 1'b0, 16'h0001, 1'b0);
        check("p1_tos", 32'(tos), 32'h0001);
        check("p1_nos", 32'(nos), 0);
        step(1'b1, 1'b0, 16'h0100, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b0);
        check("p3_tos", 32'(tos), 32'hFFFF);
        check("p3_nos", 32'(nos), 32'h0100);
        check("p3_count", 32'(count), 3);
        check("p3_empty", 32'(empty), 0);
        check("p3_full", 32'(full), 0);

        // Three pops
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("pop1_tos", 32'(tos), 32'h0100);
        check("pop1_nos", 32'(nos), 32'h0001);
        check("pop1_count", 32'(count), 2);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("pop2_tos", 32'(tos), 32'h0001);
        check("pop2_nos", 32'(nos), 0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("pop3_tos", 32'(tos), 0);
        check("pop3_nos", 32'(nos), 0);
        check("pop3_count", 32'(count), 0);
        check("pop3_empty", 32'(empty), 1);
        check("pop3_unf", 32'(underflow), 0);

        // Fill to 16
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 16'(i), 1'b0);
        end
        check("fill15_count", 32'(count), 15);
        check("fill15_full", 32'(full), 0);
        step(1'b1, 1'b0, 16'd15, 1'b0);
        check("fill_full", 32'(full), 1);
        check("fill_tos", 32'(tos), 15);
        check("fill_nos", 32'(nos), 14);
        check("fill_count", 32'(count), 16);

        // Push while full
        step(1'b1, 1'b0, 16'hAAAA, 1'b0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_tos", 32'(tos), 15);
        check("ovf_nos", 32'(nos), 14);
        check("ovf_count", 32'(count), 16);
        idle();
        check("ovf_sticky", 32'(overflow), 1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        // Pops from full exercise the deep read path
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("deep1_tos", 32'(tos), 14);
        check("deep1_nos", 32'(nos), 13);
        check("deep1_full", 32'(full), 0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("deep2_tos", 32'(tos), 13);
        check("deep2_nos", 32'(nos), 12);

        // Replace top with count == 2, then confirm the memory slot was rewritten
        do_reset();
        step(1'b1, 1'b0, 16'd3, 1'b0);
        step(1'b1, 1'b0, 16'd7, 1'b0);
        check("pre_rep_tos", 32'(tos), 7);
        check("pre_rep_nos", 32'(nos), 3);
        step(1'b1, 1'b1, 16'd9, 1'b0);
        check("rep_tos", 32'(tos), 9);
        check("rep_nos", 32'(nos), 3);
        check("rep_count", 32'(count), 2);
        check("rep_unf", 32'(underflow), 0);
        step(1'b1, 1'b0, 16'd4, 1'b0);
        step(1'b1, 1'b0, 16'd6, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("rep_mem_tos", 32'(tos), 4);
        check("rep_mem_nos", 32'(nos), 9);

        // Push+pop on empty acts as a push
        do_reset();
        step(1'b1, 1'b1, 16'd5, 1'b0);
        check("pp_empty_tos", 32'(tos), 5);
        check("pp_empty_nos", 32'(nos), 0);
        check("pp_empty_count", 32'(count), 1);
        check("pp_empty_unf", 32'(underflow), 0);

        // Underflow
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("pop_to_empty", 32'(count), 0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        check("unf_flag", 32'(underflow), 1);
        check("unf_tos", 32'(tos), 0);
        check("unf_nos", 32'(nos), 0);
        check("unf_count", 32'(count), 0);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        check("unf_clr_race", 32'(underflow), 1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("unf_clr", 32'(underflow), 0);

        // Reset mid-sequence with a push pending
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0);
        end
        check("pre_rst_count", 32'(count), 5);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 16'hBEEF, 1'b0);
        rst_n = 1'b1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_tos", 32'(tos), 0);
        check("mid_rst_nos", 32'(nos), 0);
        check("mid_rst_empty", 32'(empty), 1);
        step(1'b1, 1'b0, 16'h0001, 1'b0);
        check("post_rst_tos", 32'(tos), 1);
        check("post_rst_nos", 32'(nos), 0);
        check("post_rst_count", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_stack_unit

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- 16-bit LIFO data stack for the stack processor. It holds operands between the datapath registers and the ALU.
- Upstream, it accepts data words from the register stage's read data on push.
- Downstream, it presents the top-of-stack (TOS) and next-on-stack (NOS) values, fully registered, to the ALU operand inputs.
- Flags report occupancy and misuse so the control unit can detect and trap stack errors.

Parameters:
WIDTH, 16, data word width in bits
ADDR_W, 4, stack pointer width; DEPTH = 2**ADDR_W entries (default 16)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
push  input  1  push w_data this cycle
pop  input  1  pop top entry this cycle
w_data  input  WIDTH  word to push
err_clr  input  1  clears the sticky overflow/underflow flags
tos  output  WIDTH  current top entry; 0 when empty
nos  output  WIDTH  entry below top; 0 when count < 2
count  output  ADDR_W+1  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at a rising edge):
  - count=0, tos=0, nos=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage array contents are not reset.
  - Reset has priority over every other input, including a reset asserted mid-sequence.
- Timing: all outputs are registered. The effect of push/pop at edge N is visible right after edge N, i.e. the following cycle. No combinational input-to-output paths.
- Push only, not full: mem[count]<=w_data; count+1; tos<=w_data; nos<=old tos.
- Push only, full: ignored; state unchanged; overflow<=1.
- Pop only, count>=1: count-1; tos<=old nos; nos<=mem[count-3] if count>=3, else 0.
- Pop only, empty: ignored; tos and nos stay 0; underflow<=1.
- Push and pop together, count>=1 (full included): replace top. mem[count-1]<=w_data; tos<=w_data; count and nos unchanged; no flag set.
- Push and pop together, empty: treated as push only; no underflow.
- Flags:
  - empty and full are derived from the next count and registered alongside it.
  - overflow and underflow stay set until err_clr or reset.
  - err_clr in the same cycle as a new error: the error wins (flag ends at 1).
- Arithmetic: count never wraps. Valid range is 0..DEPTH; writes use index count[ADDR_W-1:0].
- No X may appear on tos/nos after reset. Read indices are guarded so uninitialised entries are never selected when count < 3.

Decomposition:
- Shared package holds:
  - WIDTH default (16), shared with the register and ALU.
  - Opcode-independent stack constants: STACK_ADDR_W default.
  - Flag bit positions, used if the control unit packs flags into a status word.
- One natural sub-module, stack_mem: DEPTH x WIDTH storage with a synchronous write port and an asynchronous read port indexed by count-3 (deeper reads).
- TOS/NOS registers, count and flags stay in stack_unit.

Test Plan:
- Reset, then push 1, 256, 0xFFFF on consecutive cycles -> tos=0xFFFF, nos=256, count=3, empty=0, full=0.
- From that state, pop three times -> tos/nos go 256/1, then 1/0, then 0/0; count=0; empty=1; underflow=0.
- Push 16 words 0..15 -> full=1, tos=15, nos=14. A 17th push of 0xAAAA -> overflow=1, tos=15, count=16. err_clr -> overflow=0.
- With count=2 (tos=7, nos=3), assert push+pop with w_data=9 -> tos=9, nos=3, count=2. From empty, push+pop with w_data=5 -> tos=5, count=1, underflow=0.
- Pop while empty -> underflow=1, tos=0. Pop together with err_clr while empty -> underflow stays 1.
- With count=5, assert rst_n=0 for one edge together with push=1 -> count=0, tos=0, nos=0, empty=1; the pushed word is not retained.
